mesa_rx_uart_p: RTL and testbench

Parametrised, fixed-baud, receive-only UART. Successor to the single-format 8N1 receiver.
- Configurable data width, parity and stop-bit count.
- 3-sample majority vote around mid-bit; false-start rejection.
- Parity, framing and break detection.
- First-word-fall-through (FWFT) receive FIFO with sticky overrun.
Sits between the board-level RXD pin and the mesa byte/packet decoders. Consumers pop words instead of having to catch single-cycle strobes.

---
 rtl/mesa_rx_uart_p_pkg.sv | 14 +
 rtl/mesa_rx_uart_p_if.sv | 13 +
 rtl/mesa_rx_uart_p_fifo.sv | 39 +++
 rtl/mesa_rx_uart_p.sv | 111 +++++++++++
 tb/tb_mesa_rx_uart_p.sv | 117 +++++++++++
 5 files changed

// File: rtl/mesa_rx_uart_p_pkg.sv
// mesa_uart_pkg: shared state encodings, status bit offsets and limits for the mesa UART receiver.
package mesa_uart_pkg;
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] START    = 3'd1;
   localparam logic [2:0] DATA     = 3'd2;
   localparam logic [2:0] PARITY   = 3'd3;
   localparam logic [2:0] STOP     = 3'd4;
   localparam logic [2:0] BRK_WAIT = 3'd5;
   // Status bit positions, counted from the bit just above the data field.
   localparam int BRK_IDX  = 2;
   localparam int FERR_IDX = 1;
   localparam int PERR_IDX = 0;
   localparam int MIN_BAUD = 4;
endpackage

// File: rtl/mesa_rx_uart_p_if.sv
// mesa_rx_uart_p_if: line input, baud setting and FIFO read port of the receiver.
interface mesa_rx_uart_p_if #(parameter int DATA_BITS = 8);
   logic                 rxd;
   logic [15:0]          baud_rate;
   logic                 rd_en;
   logic [DATA_BITS+2:0] rd_data;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 overrun;
   logic                 ovr_clr;
   modport master (output rxd, baud_rate, rd_en, ovr_clr, input rd_data, fifo_empty, fifo_full, overrun);
   modport slave  (input rxd, baud_rate, rd_en, ovr_clr, output rd_data, fifo_empty, fifo_full, overrun);
endinterface

// File: rtl/mesa_rx_uart_p_fifo.sv
// mesa_sync_fifo: first-word-fall-through FIFO; a write while full is accepted only alongside a pop.
module mesa_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_drop
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [AW:0]      r_cnt;
   logic             w_push, w_pop;
   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign w_pop   = i_rd & ~o_empty;
   assign w_push  = i_wr & (~o_full | w_pop);
   assign o_drop  = i_wr & o_full & ~w_pop;
   assign o_rdata = o_empty ? '0 : r_mem[r_rp];
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_wdata;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + AW'(w_push);
         r_rp  <= r_rp + AW'(w_pop);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
endmodule

// File: rtl/mesa_rx_uart_p.sv
// mesa_rx_uart_p: parametrised receive-only UART with majority-vote sampling, error/break flags and FWFT FIFO.
module mesa_rx_uart_p
   import mesa_uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input logic             clk,
   input logic             reset,
   mesa_rx_uart_p_if.slave bus
);
   localparam int W = DATA_BITS + 3;
   logic                 r_s1, r_s2, r_hist;
   logic [2:0]           r_state;
   logic [15:0]          r_cnt;
   logic [1:0]           r_smp;
   logic [3:0]           r_bits;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_perr, r_ferr, r_zero, r_push, r_ovr;
   logic [W-1:0]         r_word;
   logic [15:0]          w_baud, w_mid;
   logic                 w_dec, w_vote, w_brk, w_drop;
   logic [2:0]           w_stat;
   assign w_baud = (bus.baud_rate < 16'(MIN_BAUD)) ? 16'(MIN_BAUD) : bus.baud_rate;
   assign w_mid  = w_baud >> 1;
   assign w_dec  = (r_state != IDLE) && (r_state != BRK_WAIT) && (r_cnt == w_mid + 16'd1);
   assign w_vote = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_s2) | (r_smp[1] & r_s2);
   assign w_brk  = (r_state == STOP) && (r_bits == '0) && r_zero && !w_vote;
   always_comb begin
      w_stat           = '0;
      w_stat[BRK_IDX]  = w_brk;
      w_stat[FERR_IDX] = r_ferr | ~w_vote;
      w_stat[PERR_IDX] = r_perr;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) {r_s1, r_s2, r_hist} <= 3'b111;
      else       {r_s1, r_s2, r_hist} <= {bus.rxd, r_s1, r_s2};
   // The counter idles at 1 so the start edge leaves it aligned to the bit boundary.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_cnt <= 16'd1;
         r_smp <= '0;
      end else begin
         r_cnt <= (r_state == IDLE || r_cnt >= w_baud) ? 16'd1 : r_cnt + 16'd1;
         if (r_cnt == w_mid - 16'd1) r_smp[0] <= r_s2;
         if (r_cnt == w_mid) r_smp[1] <= r_s2;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= IDLE;
         r_bits  <= '0;
         r_data  <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_zero  <= 1'b1;
         r_push  <= 1'b0;
         r_word  <= '0;
      end else begin
         r_push <= 1'b0;
         case (r_state)
            IDLE: if (r_hist & ~r_s2) r_state <= START;
            START: if (w_dec) begin
               r_state <= w_vote ? IDLE : DATA;
               r_bits  <= '0;
               r_perr  <= 1'b0;
               r_ferr  <= 1'b0;
               r_zero  <= 1'b1;
            end
            DATA: if (w_dec) begin
               r_data <= {w_vote, r_data[DATA_BITS-1:1]};
               r_zero <= r_zero & ~w_vote;
               r_bits <= (r_bits == 4'(DATA_BITS-1)) ? '0 : r_bits + 4'd1;
               if (r_bits == 4'(DATA_BITS-1)) r_state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (w_dec) begin
               r_perr  <= ^r_data ^ w_vote ^ 1'(PARITY_ODD);
               r_zero  <= r_zero & ~w_vote;
               r_state <= STOP;
            end
            STOP: if (w_dec) begin
               r_bits <= r_bits + 4'd1;
               r_ferr <= r_ferr | ~w_vote;
               if (w_brk || r_bits == 4'(STOP_BITS-1)) begin
                  r_push  <= 1'b1;
                  r_word  <= {w_stat, r_data};
                  r_state <= w_brk ? BRK_WAIT : IDLE;
               end
            end
            BRK_WAIT: if (r_s2) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) r_ovr <= 1'b0;
      else       r_ovr <= w_drop | (r_ovr & ~bus.ovr_clr);
   assign bus.overrun = r_ovr;
   mesa_sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (r_push),
      .i_wdata (r_word),
      .i_rd    (bus.rd_en),
      .o_rdata (bus.rd_data),
      .o_empty (bus.fifo_empty),
      .o_full  (bus.fifo_full),
      .o_drop  (w_drop)
   );
endmodule

// File: tb/tb_mesa_rx_uart_p.sv
// tb_mesa_rx_uart_p: directed table-driven bench for an 8N1 and an 8E1 receiver instance.
module tb_mesa_rx_uart_p;
   localparam int BAUD = 10;
   typedef struct {
      int         dut;
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         idle;
      logic [10:0] exp;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   vec_t tbl[8];
   mesa_rx_uart_p_if #(.DATA_BITS(8)) b0();
   mesa_rx_uart_p_if #(.DATA_BITS(8)) b1();
   mesa_rx_uart_p u0 (.clk(clk), .reset(reset), .bus(b0));
   mesa_rx_uart_p #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .reset(reset), .bus(b1));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic line(input int d, input logic v, input int n);
      if (d == 0) b0.rxd = v;
      else        b1.rxd = v;
      repeat (n) @(negedge clk);
   endtask
   task automatic send(input int d, input logic [7:0] data, input logic par, input logic stop, input int idle);
      line(d, 1'b0, BAUD);
      for (int i = 0; i < 8; i++) line(d, data[i], BAUD);
      if (d == 1) line(d, par, BAUD);
      line(d, stop, BAUD);
      line(d, 1'b1, idle * BAUD);
   endtask
   task automatic pop(input int d);
      if (d == 0) b0.rd_en = 1'b1;
      else        b1.rd_en = 1'b1;
      @(negedge clk);
      b0.rd_en = 1'b0;
      b1.rd_en = 1'b0;
   endtask
   initial begin
      tbl[0] = '{0, 8'h55, 1'b0, 1'b1, 0, 11'h055};
      tbl[1] = '{0, 8'hA3, 1'b0, 1'b1, 0, 11'h0A3};
      tbl[2] = '{0, 8'h3C, 1'b0, 1'b0, 2, 11'h23C};
      tbl[3] = '{0, 8'h11, 1'b0, 1'b1, 2, 11'h011};
      tbl[4] = '{1, 8'h07, 1'b1, 1'b1, 0, 11'h007};
      tbl[5] = '{1, 8'h07, 1'b0, 1'b1, 0, 11'h107};
      tbl[6] = '{1, 8'h00, 1'b0, 1'b1, 0, 11'h000};
      tbl[7] = '{1, 8'hFF, 1'b0, 1'b1, 2, 11'h0FF};
      b0.rxd = 1'b1; b0.baud_rate = 16'(BAUD); b0.rd_en = 1'b0; b0.ovr_clr = 1'b0;
      b1.rxd = 1'b1; b1.baud_rate = 16'(BAUD); b1.rd_en = 1'b0; b1.ovr_clr = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_empty", 32'(b0.fifo_empty), 1);
      check("reset_full", 32'(b0.fifo_full), 0);
      check("reset_overrun", 32'(b0.overrun), 0);
      check("reset_rd_data", 32'(b0.rd_data), 0);
      line(0, 1'b0, 3);
      line(0, 1'b1, 20 * BAUD);
      check("glitch_empty", 32'(b0.fifo_empty), 1);
      for (int i = 0; i < 8; i++) send(tbl[i].dut, tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].idle);
      check("tbl_full0", 32'(b0.fifo_full), 1);
      check("tbl_full1", 32'(b1.fifo_full), 1);
      check("tbl_no_overrun", 32'(b0.overrun), 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tbl_word%0d", i), 32'(tbl[i].dut == 0 ? b0.rd_data : b1.rd_data), 32'(tbl[i].exp));
         pop(tbl[i].dut);
      end
      check("tbl_drained0", 32'(b0.fifo_empty), 1);
      check("tbl_drained1", 32'(b1.fifo_empty), 1);
      line(0, 1'b0, 30 * BAUD);
      check("brk_one_word", 32'(b0.fifo_empty), 0);
      line(0, 1'b1, 3 * BAUD);
      check("brk_word", 32'(b0.rd_data), 32'h600);
      pop(0);
      check("brk_only_one", 32'(b0.fifo_empty), 1);
      for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b1, 1);
      check("ovr_full", 32'(b0.fifo_full), 1);
      check("ovr_set", 32'(b0.overrun), 1);
      b0.ovr_clr = 1'b1;
      @(negedge clk);
      b0.ovr_clr = 1'b0;
      check("ovr_clr", 32'(b0.overrun), 0);
      send(0, 8'h66, 1'b0, 1'b1, 1);
      check("ovr_again", 32'(b0.overrun), 1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovr_word%0d", i), 32'(b0.rd_data), i);
         pop(0);
      end
      check("ovr_sticky", 32'(b0.overrun), 1);
      send(0, 8'h42, 1'b0, 1'b1, 1);
      check("pre_reset_word", 32'(b0.rd_data), 32'h042);
      line(0, 1'b0, BAUD);
      line(0, 1'b1, 2 * BAUD);
      line(0, 1'b0, BAUD);
      #3 reset = 1'b1;
      #1;
      check("midrst_empty", 32'(b0.fifo_empty), 1);
      check("midrst_overrun", 32'(b0.overrun), 0);
      check("midrst_rd_data", 32'(b0.rd_data), 0);
      b0.rxd = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (15 * BAUD) @(negedge clk);
      check("midrst_no_push", 32'(b0.fifo_empty), 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
